// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the load/store and fetch path: LSB op codes,
// memory controller state encoding and access-size decoding.
package mem_ctrl_pkg;

    typedef enum logic [5:0] {
        OP_NONE = 6'd0,
        OP_LB   = 6'd1,
        OP_LH   = 6'd2,
        OP_LW   = 6'd3,
        OP_LBU  = 6'd4,
        OP_LHU  = 6'd5,
        OP_SB   = 6'd6,
        OP_SH   = 6'd7,
        OP_SW   = 6'd8
    } ls_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_STORE = 2'd3
    } mem_state_e;

    function automatic logic [2:0] op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating LSB loads/stores and instruction
// fetches onto an 8-bit RAM with one-cycle read latency and a UART IO window.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        ls_req,
    input  logic [5:0]  ls_op,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_data,
    output logic        ls_valid,
    output logic [31:0] ls_res,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_data,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    mem_state_e  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] buf_q, buf_d;
    logic        ls_valid_q, ls_valid_d;
    logic [31:0] ls_res_q, ls_res_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;

    logic [2:0]  acc_size;
    logic [1:0]  rd_idx;
    logic [31:0] next_a;

    function automatic logic [31:0] load_extend(input logic [5:0] op, input logic [31:0] w);
        case (op)
            OP_LB:   return {{24{w[7]}}, w[7:0]};
            OP_LH:   return {{16{w[15]}}, w[15:0]};
            OP_LBU:  return {24'h0, w[7:0]};
            OP_LHU:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic io_blocked(input logic [31:0] a, input logic full);
        return (a >= IO_BASE) && full;
    endfunction

    assign acc_size = (state_q == S_FETCH) ? 3'd4 : op_size(op_q);
    // Byte arriving on mem_din belongs to the address driven one cycle earlier.
    assign rd_idx   = 2'(cnt_q - 3'd1);
    assign next_a   = addr_q + 32'(cnt_q) + 32'd1;

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        data_d     = data_q;
        buf_d      = buf_q;
        ls_valid_d = ls_valid_q;
        ls_res_d   = ls_res_q;
        if_valid_d = if_valid_q;
        if_data_d  = if_data_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;

        if (rdy) begin
            ls_valid_d = 1'b0;
            if_valid_d = 1'b0;
            mem_wr_d   = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    // A valid pulse is the requester's cue to drop its request; skip that cycle.
                    if (!rollback && !ls_valid_q && !if_valid_q) begin
                        if (ls_req) begin
                            op_d    = ls_op;
                            addr_d  = ls_addr;
                            data_d  = ls_data;
                            cnt_d   = 3'd0;
                            buf_d   = 32'h0;
                            mem_a_d = ls_addr;
                            if (op_is_store(ls_op)) begin
                                state_d    = S_STORE;
                                mem_dout_d = ls_data[7:0];
                                mem_wr_d   = !io_blocked(ls_addr, io_buffer_full);
                            end else begin
                                state_d = S_LOAD;
                            end
                        end else if (if_req) begin
                            addr_d  = if_addr;
                            cnt_d   = 3'd0;
                            buf_d   = 32'h0;
                            mem_a_d = if_addr;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_LOAD, S_FETCH: begin
                    if (rollback) begin
                        state_d = S_IDLE;
                        cnt_d   = 3'd0;
                        mem_a_d = 32'h0;
                    end else begin
                        if (cnt_q != 3'd0) buf_d[{rd_idx, 3'b000} +: 8] = mem_din;
                        cnt_d = cnt_q + 3'd1;
                        // Park the bus at 0 once the last byte is addressed so IO reads are not repeated.
                        mem_a_d = (cnt_q + 3'd1 < acc_size) ? next_a : 32'h0;
                        if (cnt_q == acc_size) begin
                            state_d = S_IDLE;
                            cnt_d   = 3'd0;
                            if (state_q == S_FETCH) begin
                                if_valid_d = 1'b1;
                                if_data_d  = buf_d;
                            end else begin
                                ls_valid_d = 1'b1;
                                ls_res_d   = load_extend(op_q, buf_d);
                            end
                        end
                    end
                end
                S_STORE: begin
                    if (mem_wr_q) begin
                        if (cnt_q + 3'd1 == acc_size) begin
                            state_d    = S_IDLE;
                            cnt_d      = 3'd0;
                            ls_valid_d = 1'b1;
                            mem_a_d    = 32'h0;
                        end else begin
                            cnt_d      = cnt_q + 3'd1;
                            mem_a_d    = next_a;
                            mem_dout_d = byte_of(data_q, 2'(cnt_q + 3'd1));
                            mem_wr_d   = !io_blocked(next_a, io_buffer_full);
                        end
                    end else begin
                        mem_wr_d = !io_blocked(mem_a_q, io_buffer_full);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            op_q       <= 6'd0;
            addr_q     <= 32'h0;
            data_q     <= 32'h0;
            buf_q      <= 32'h0;
            ls_valid_q <= 1'b0;
            ls_res_q   <= 32'h0;
            if_valid_q <= 1'b0;
            if_data_q  <= 32'h0;
            mem_a_q    <= 32'h0;
            mem_dout_q <= 8'h0;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            buf_q      <= buf_d;
            ls_valid_q <= ls_valid_d;
            ls_res_q   <= ls_res_d;
            if_valid_q <= if_valid_d;
            if_data_q  <= if_data_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    assign ls_valid = ls_valid_q;
    assign ls_res   = ls_res_q;
    assign if_valid = if_valid_q;
    assign if_data  = if_data_q;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    // A held write must not repeat while the system is stalled.
    assign mem_wr   = mem_wr_q && rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, directed corner cases and
// randomized loads/stores/fetches checked against an array-based memory model.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam logic [31:0] IO_BASE = 32'h0003_0000;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback;
    logic        ls_req;
    logic [5:0]  ls_op;
    logic [31:0] ls_addr, ls_data;
    logic        ls_valid;
    logic [31:0] ls_res;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_data;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int total  = 0;
    int passed = 0;

    logic [7:0]  ram     [0:4095];
    logic [7:0]  exp_mem [0:4095];
    logic [31:0] wr_a [$];
    logic [7:0]  wr_d [$];

    ls_op_e op_tab [8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

    always #5 clk = ~clk;

    mem_ctrl #(.IO_BASE(IO_BASE)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .ls_req(ls_req), .ls_op(ls_op), .ls_addr(ls_addr), .ls_data(ls_data),
        .ls_valid(ls_valid), .ls_res(ls_res),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    // RAM with registered read; the 4 KiB array aliases on the low 12 address bits.
    always @(posedge clk) begin
        if (mem_wr === 1'b1 && mem_a < IO_BASE) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    always @(posedge clk) begin
        if (mem_wr === 1'b1) begin
            wr_a.push_back(mem_a);
            wr_d.push_back(mem_dout);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int size_of(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            default:              return 4;
        endcase
    endfunction

    function automatic bit is_store(input logic [5:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a);
        logic [31:0] word = 32'h0;
        logic [31:0] ba;
        for (int k = 0; k < size_of(op); k++) begin
            ba   = a + 32'(k);
            word = word | (32'(exp_mem[ba[11:0]]) << (8 * k));
        end
        if (op == OP_LB && word >= 32'h80)   word = word + 32'hFFFF_FF00;
        if (op == OP_LH && word >= 32'h8000) word = word + 32'hFFFF_0000;
        return word;
    endfunction

    task automatic model_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ba;
        for (int k = 0; k < size_of(op); k++) begin
            ba = a + 32'(k);
            if (ba < IO_BASE) exp_mem[ba[11:0]] = d[8*k +: 8];
        end
    endtask

    task automatic check_writes(input string tag, input logic [5:0] op, input logic [31:0] a,
                                input logic [31:0] d);
        int n = size_of(op);
        check({tag, "_nwr"}, 32'(wr_a.size()), 32'(n));
        for (int k = 0; k < n && k < wr_a.size(); k++) begin
            check({tag, "_wa"}, wr_a[k], a + 32'(k));
            check({tag, "_wd"}, 32'(wr_d[k]), 32'(d[8*k +: 8]));
        end
    endtask

    task automatic wait_valid(input bit want_if, output int lat, output logic [31:0] res);
        lat = -1;
        res = 32'h0;
        for (int i = 1; i <= 60 && lat < 0; i++) begin
            @(negedge clk);
            if (want_if ? if_valid : ls_valid) begin
                lat = i;
                res = want_if ? if_data : ls_res;
            end
        end
    endtask

    // Latency counts negedges from request presentation: one edge to accept,
    // then a load's valid lands N+1 cycles in, a store's N cycles in.
    task automatic do_ls(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d,
                         input string tag, output logic [31:0] res);
        int lat;
        int n = size_of(op);
        logic [31:0] exp = model_load(op, a);
        wr_a.delete();
        wr_d.delete();
        @(negedge clk);
        ls_op = op; ls_addr = a; ls_data = d; ls_req = 1'b1;
        wait_valid(1'b0, lat, res);
        ls_req = 1'b0;
        if (is_store(op)) begin
            check({tag, "_lat"}, 32'(lat), 32'(n + 1));
            model_store(op, a, d);
        end else begin
            check({tag, "_lat"}, 32'(lat), 32'(n + 2));
            check({tag, "_res"}, res, exp);
        end
        @(negedge clk);
        check({tag, "_pulse"}, 32'(ls_valid), 32'h0);
        if (is_store(op)) check_writes(tag, op, a, d);
        else check({tag, "_nowr"}, 32'(wr_a.size()), 32'h0);
    endtask

    task automatic do_fetch(input logic [31:0] a, input string tag);
        int lat;
        logic [31:0] res;
        logic [31:0] exp = model_load(OP_LW, a);
        @(negedge clk);
        if_addr = a; if_req = 1'b1;
        wait_valid(1'b1, lat, res);
        if_req = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'd6);
        check({tag, "_data"}, res, exp);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(if_valid), 32'h0);
    endtask

    initial begin
        logic [31:0] res, res_ls, res_if, exp_f, fetch_a, d;
        int lat, ls_lat, if_lat, overlap, seen;

        for (int i = 0; i < 4096; i++) begin
            ram[i]     = 8'($urandom);
            exp_mem[i] = ram[i];
        end
        ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
        ram[12'h200] = 8'h80;
        exp_mem[12'h100] = 8'h78; exp_mem[12'h101] = 8'h56;
        exp_mem[12'h102] = 8'h34; exp_mem[12'h103] = 8'h12;
        exp_mem[12'h200] = 8'h80;

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        ls_req = 1'b0; ls_op = 6'd0; ls_addr = 32'h0; ls_data = 32'h0;
        if_req = 1'b0; if_addr = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ls_valid", 32'(ls_valid), 32'h0);
        check("rst_if_valid", 32'(if_valid), 32'h0);
        check("rst_ls_res", ls_res, 32'h0);
        check("rst_if_data", if_data, 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_dout", 32'(mem_dout), 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(S_IDLE));
        rst = 1'b0;

        do_ls(OP_LW, 32'h100, 32'h0, "lw_100", res);
        check("lw_100_const", res, 32'h1234_5678);
        do_ls(OP_LB, 32'h200, 32'h0, "lb_200", res);
        check("lb_200_const", res, 32'hFFFF_FF80);
        do_ls(OP_LBU, 32'h200, 32'h0, "lbu_200", res);
        check("lbu_200_const", res, 32'h0000_0080);
        do_ls(OP_SH, 32'h10, 32'h0000_ABCD, "sh_10", res);
        check("sh_10_byte0", 32'(wr_d.size() > 0 ? wr_d[0] : 8'h00), 32'hCD);
        do_ls(OP_LH, 32'h10, 32'h0, "lh_10", res);
        check("lh_10_const", res, 32'hFFFF_ABCD);
        do_ls(OP_LHU, 32'h10, 32'h0, "lhu_10", res);
        check("lhu_10_const", res, 32'h0000_ABCD);
        do_ls(OP_LW, 32'hFFFF_FFFE, 32'h0, "lw_wrap", res);
        do_ls(OP_SW, 32'hFFF, 32'hCAFE_F00D, "sw_wrap12", res);
        do_fetch(32'h100, "fetch_100");

        // Simultaneous requests: LSB first, fetch accepted the cycle after ls_valid.
        exp_f = model_load(OP_LW, 32'h40);
        @(negedge clk);
        ls_op = OP_LW; ls_addr = 32'h100; ls_req = 1'b1;
        if_addr = 32'h40; if_req = 1'b1;
        ls_lat = -1; if_lat = -1; overlap = 0; fetch_a = 32'hDEAD_BEEF;
        res_ls = 32'h0; res_if = 32'h0;
        for (int i = 1; i <= 40 && if_lat < 0; i++) begin
            @(negedge clk);
            if (ls_valid && if_valid) overlap++;
            if (ls_valid && ls_lat < 0) begin
                ls_lat = i; ls_req = 1'b0; res_ls = ls_res;
            end
            if (if_valid) begin
                if_lat = i; if_req = 1'b0; res_if = if_data;
            end
            if (ls_lat > 0 && i == ls_lat + 2) fetch_a = mem_a;
        end
        check("prio_ls_lat", 32'(ls_lat), 32'd6);
        check("prio_if_gap", 32'(if_lat - ls_lat), 32'd7);
        check("prio_fetch_a", fetch_a, 32'h40);
        check("prio_overlap", 32'(overlap), 32'h0);
        check("prio_ls_res", res_ls, 32'h1234_5678);
        check("prio_if_data", res_if, exp_f);
        @(negedge clk);
        check("prio_if_pulse", 32'(if_valid), 32'h0);

        // Rollback during cycle 2 of a word load.
        @(negedge clk);
        ls_op = OP_LW; ls_addr = 32'h104; ls_req = 1'b1;
        repeat (3) @(negedge clk);
        rollback = 1'b1; ls_req = 1'b0;
        @(negedge clk);
        rollback = 1'b0;
        check("rb_load_idle", 32'(dut.state_q), 32'(S_IDLE));
        check("rb_load_wr", 32'(mem_wr), 32'h0);
        seen = 0;
        repeat (8) begin
            if (ls_valid) seen++;
            @(negedge clk);
        end
        check("rb_load_novalid", 32'(seen), 32'h0);

        // Rollback in IDLE blocks acceptance for that cycle only.
        @(negedge clk);
        ls_op = OP_LBU; ls_addr = 32'h200; ls_req = 1'b1; rollback = 1'b1;
        @(negedge clk);
        rollback = 1'b0;
        check("rb_idle_block", 32'(dut.state_q), 32'(S_IDLE));
        wait_valid(1'b0, lat, res);
        ls_req = 1'b0;
        check("rb_idle_lat", 32'(lat), 32'd3);
        check("rb_idle_res", res, 32'h80);
        @(negedge clk);

        // Rollback during a store is ignored.
        d = $urandom;
        wr_a.delete(); wr_d.delete();
        @(negedge clk);
        ls_op = OP_SW; ls_addr = 32'h20; ls_data = d; ls_req = 1'b1;
        @(negedge clk);
        rollback = 1'b1;
        @(negedge clk);
        rollback = 1'b0;
        wait_valid(1'b0, lat, res);
        ls_req = 1'b0;
        check("rb_store_lat", 32'(lat + 2), 32'd5);
        model_store(OP_SW, 32'h20, d);
        @(negedge clk);
        check_writes("rb_store", OP_SW, 32'h20, d);
        do_ls(OP_LW, 32'h20, 32'h0, "rb_store_rd", res);

        // IO store held while the UART buffer is full.
        wr_a.delete(); wr_d.delete();
        io_buffer_full = 1'b1;
        @(negedge clk);
        ls_op = OP_SB; ls_addr = IO_BASE; ls_data = 32'h0000_005A; ls_req = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_wr) seen++;
        end
        check("io_hold_wr", 32'(seen), 32'h0);
        io_buffer_full = 1'b0;
        wait_valid(1'b0, lat, res);
        ls_req = 1'b0;
        check("io_release_lat", 32'(lat), 32'd2);
        @(negedge clk);
        check_writes("io_sb", OP_SB, IO_BASE, 32'h0000_005A);

        // rdy low for two edges during a word store.
        d = $urandom;
        wr_a.delete(); wr_d.delete();
        @(negedge clk);
        ls_op = OP_SW; ls_addr = 32'h80; ls_data = d; ls_req = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (mem_wr) seen++;
        end
        check("rdy_low_wr", 32'(seen), 32'h0);
        rdy = 1'b1;
        wait_valid(1'b0, lat, res);
        ls_req = 1'b0;
        check("rdy_store_lat", 32'(lat + 3), 32'd7);
        model_store(OP_SW, 32'h80, d);
        @(negedge clk);
        check_writes("rdy_store", OP_SW, 32'h80, d);

        // Reset in the middle of a load abandons it.
        @(negedge clk);
        ls_op = OP_LW; ls_addr = 32'h100; ls_req = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; ls_req = 1'b0;
        @(negedge clk);
        check("mid_rst_ls_res", ls_res, 32'h0);
        check("mid_rst_mem_a", mem_a, 32'h0);
        check("mid_rst_state", 32'(dut.state_q), 32'(S_IDLE));
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ls_valid) seen++;
        end
        check("mid_rst_novalid", 32'(seen), 32'h0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0)
                do_fetch(32'($urandom_range(0, 1023)) << 2, "rand_fetch");
            else
                do_ls(op_tab[$urandom_range(0, 7)], 32'($urandom_range(0, 4095)), $urandom,
                      "rand_ls", res);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h0003_0000; addresses at or above it are IO space.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- rollback  in  1  branch mispredict flush.
- ls_req  in  1  LSB access request (level).
- ls_op  in  6  LB/LH/LW/LBU/LHU/SB/SH/SW code.
- ls_addr  in  32  byte address.
- ls_data  in  32  store data.
- ls_valid  out  1  LSB access done (1-cycle pulse).
- ls_res  out  32  extended load result.
- if_req  in  1  instruction fetch request (level).
- if_addr  in  32  fetch address, word aligned.
- if_valid  out  1  fetch done (1-cycle pulse).
- if_data  out  32  fetched instruction.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write, 0 = read.
- io_buffer_full  in  1  UART buffer full.

Function
REQ-003 SHALL implement FSM states IDLE, FETCH, LOAD, STORE, plus a byte counter cnt[2:0] and a 32-bit assembly register.
REQ-004 In IDLE, SHALL accept ls_req before if_req (LSB priority), latch op/addr/data, clear cnt, and enter LOAD or STORE per op.
REQ-005 In IDLE, SHALL start FETCH only when if_req=1 and ls_req=0.
REQ-006 SHALL set access size: 1 byte for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW/FETCH.
REQ-007 Read (LOAD/FETCH): cycle k SHALL drive mem_a=addr+k with mem_wr=0; the byte on mem_din in cycle k+1 SHALL be byte k, assembled little-endian.
REQ-008 Read latency: for N bytes, SHALL pulse the valid output N+1 cycles after entry, then return to IDLE.
REQ-009 ls_res SHALL be sign-extended for LB/LH and zero-extended for LBU/LHU; SHALL carry the full word for LW.
REQ-010 Write (STORE): cycle k SHALL drive mem_a=addr+k, mem_dout=data[8k+7:8k], mem_wr=1.
REQ-011 After the last store byte, SHALL pulse ls_valid in the next cycle, with mem_wr=0 in that cycle.
REQ-012 Store to addr >= IO_BASE while io_buffer_full=1 SHALL hold the current byte (mem_wr=0, cnt unchanged) until io_buffer_full=0.
REQ-013 ls_valid and if_valid SHALL never assert in the same cycle.
REQ-014 Each valid output SHALL be high exactly one cycle per accepted request.
REQ-015 A new request SHALL NOT be accepted in the cycle a valid is pulsed; the earliest next acceptance is the following cycle.
REQ-016 rollback in FETCH or LOAD SHALL abort the access: IDLE next cycle, no valid, mem_wr=0.
REQ-017 rollback in STORE SHALL be ignored; the store completes and pulses ls_valid.
REQ-018 rollback in IDLE SHALL block acceptance for that cycle.
REQ-019 When rdy=0, SHALL hold all registers and outputs, forcing mem_wr=0.
REQ-020 Address arithmetic SHALL be 32-bit wrap-around (addr+k modulo 2^32).

Reset
REQ-021 On rst: state=IDLE, cnt=0, ls_valid=0, if_valid=0, ls_res=0, if_data=0, mem_a=0, mem_dout=0, mem_wr=0.
REQ-022 rst SHALL take priority over rdy and rollback.
REQ-023 rst asserted mid-access SHALL abandon the access with no valid pulse.

Structure
REQ-024 Op codes (LB..SW) and FSM state encodings SHALL live in the shared defines package, common with the LSB and decoder.
REQ-025 SHALL be a single module with no sub-modules; a load extender function is permitted inline.

Verification
REQ-026 SHALL cover LW @0x100 with RAM bytes 78,56,34,12: ls_valid after 5 cycles, ls_res=0x12345678.
REQ-027 SHALL cover LB @0x200 with byte 0x80: ls_res=0xFFFFFF80. LBU on the same address: ls_res=0x00000080.
REQ-028 SHALL cover SH @0x10, data 0xABCD: mem_wr=1 at 0x10 with byte CD, then at 0x11 with byte AB; ls_valid on the 3rd cycle.
REQ-029 SHALL cover ls_req and if_req rising together: the LSB access is served first, the fetch starts one cycle after ls_valid, and if_valid never overlaps ls_valid.
REQ-030 SHALL cover rollback on cycle 2 of an LW: no ls_valid and IDLE next cycle.
REQ-031 SHALL cover SB to 0x30000 with io_buffer_full=1 for 3 cycles: mem_wr stays 0 until release, then one write and ls_valid.
